// File: rtl/mem_access_controller.sv
// MEM-stage sequencer: turns an EX/MEM load/store into a REQ/ACK memory transaction,
// stalls the pipeline until completion, and formats load data with sign/zero extension.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   S_IDLE   | waiting for a load/store; issues the request if it is aligned
//   S_ACCESS | DMEM_REQ high, waiting for DMEM_ACK or the timeout
//   S_DONE   | stall released for one cycle so EX/MEM advances past the access
module mem_access_controller #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MEM_READ,
    input  logic        MEM_WRITE,
    input  logic [2:0]  FUNCT3,
    input  logic [31:0] ADDRESS,
    input  logic [31:0] WRITE_DATA,
    output logic        STALL,
    output logic        DMEM_REQ,
    output logic        DMEM_WE,
    output logic [31:0] DMEM_ADDR,
    output logic [31:0] DMEM_WDATA,
    output logic [3:0]  DMEM_BYTE_EN,
    input  logic        DMEM_ACK,
    input  logic [31:0] DMEM_RDATA,
    output logic [31:0] LOAD_DATA,
    output logic        MISALIGNED,
    output logic        TIMEOUT_ERR
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] tmo_cnt;
    logic [2:0]       funct3_q;
    logic [1:0]       addr_lo_q;
    logic             acc;
    logic             aligned;
    logic             tmo_tc;
    logic [3:0]       byte_en;
    logic [31:0]      wdata_rep;

    function automatic logic [31:0] fmt_load(input logic [2:0]  f3,
                                             input logic [1:0]  lo,
                                             input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lo)
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = lo[1] ? rd[31:16] : rd[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b100:  r = {24'd0, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b101:  r = {16'd0, h};
            default: r = rd;
        endcase
        return r;
    endfunction

    assign acc    = MEM_READ | MEM_WRITE;
    assign tmo_tc = (tmo_cnt == '0);

    // Undefined FUNCT3 encodings fall into the word case everywhere below.
    always_comb begin
        aligned   = 1'b1;
        byte_en   = 4'b1111;
        wdata_rep = WRITE_DATA;
        case (FUNCT3)
            3'b000, 3'b100: begin
                byte_en   = 4'b0001 << ADDRESS[1:0];
                wdata_rep = {4{WRITE_DATA[7:0]}};
            end
            3'b001, 3'b101: begin
                aligned   = ~ADDRESS[0];
                byte_en   = 4'b0011 << {ADDRESS[1], 1'b0};
                wdata_rep = {2{WRITE_DATA[15:0]}};
            end
            default: begin
                aligned = (ADDRESS[1:0] == 2'b00);
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (acc && aligned) begin
                    state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (DMEM_ACK || tmo_tc) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        STALL = 1'b0;
        case (state)
            S_IDLE:   STALL = acc & aligned;
            S_ACCESS: STALL = 1'b1;
            default:  STALL = 1'b0;
        endcase
    end

    // Timeout is a down-counter loaded at issue; reaching zero without ACK aborts.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            tmo_cnt      <= '0;
            funct3_q     <= 3'b000;
            addr_lo_q    <= 2'b00;
            DMEM_REQ     <= 1'b0;
            DMEM_WE      <= 1'b0;
            DMEM_ADDR    <= 32'd0;
            DMEM_WDATA   <= 32'd0;
            DMEM_BYTE_EN <= 4'd0;
            LOAD_DATA    <= 32'd0;
            MISALIGNED   <= 1'b0;
            TIMEOUT_ERR  <= 1'b0;
        end else begin
            MISALIGNED <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (acc && aligned) begin
                        DMEM_REQ     <= 1'b1;
                        DMEM_WE      <= MEM_WRITE;
                        DMEM_ADDR    <= {ADDRESS[31:2], 2'b00};
                        DMEM_WDATA   <= wdata_rep;
                        DMEM_BYTE_EN <= byte_en;
                        funct3_q     <= FUNCT3;
                        addr_lo_q    <= ADDRESS[1:0];
                        tmo_cnt      <= CNT_W'(TIMEOUT_CYCLES - 1);
                    end else if (acc) begin
                        MISALIGNED <= 1'b1;
                        LOAD_DATA  <= 32'd0;
                    end
                end
                S_ACCESS: begin
                    if (DMEM_ACK) begin
                        DMEM_REQ <= 1'b0;
                        if (!DMEM_WE) begin
                            LOAD_DATA <= fmt_load(funct3_q, addr_lo_q, DMEM_RDATA);
                        end
                    end else if (tmo_tc) begin
                        DMEM_REQ    <= 1'b0;
                        TIMEOUT_ERR <= 1'b1;
                        LOAD_DATA   <= 32'd0;
                    end else begin
                        tmo_cnt <= tmo_cnt - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_controller.sv
// Bench for mem_access_controller: directed cases plus randomized accesses checked
// against an arithmetic reference model of addressing, lanes and load extension.
module tb_mem_access_controller;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [2:0]  FUNCT3;
    logic [31:0] ADDRESS;
    logic [31:0] WRITE_DATA;
    logic        STALL;
    logic        DMEM_REQ;
    logic        DMEM_WE;
    logic [31:0] DMEM_ADDR;
    logic [31:0] DMEM_WDATA;
    logic [3:0]  DMEM_BYTE_EN;
    logic        DMEM_ACK;
    logic [31:0] DMEM_RDATA;
    logic [31:0] LOAD_DATA;
    logic        MISALIGNED;
    logic        TIMEOUT_ERR;

    mem_access_controller #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
        .CLK(CLK), .RESET(RESET), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
        .FUNCT3(FUNCT3), .ADDRESS(ADDRESS), .WRITE_DATA(WRITE_DATA), .STALL(STALL),
        .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE), .DMEM_ADDR(DMEM_ADDR),
        .DMEM_WDATA(DMEM_WDATA), .DMEM_BYTE_EN(DMEM_BYTE_EN), .DMEM_ACK(DMEM_ACK),
        .DMEM_RDATA(DMEM_RDATA), .LOAD_DATA(LOAD_DATA), .MISALIGNED(MISALIGNED),
        .TIMEOUT_ERR(TIMEOUT_ERR)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // Model state and observations gathered by the access driver.
    logic [31:0] exp_ld;
    logic        exp_to;
    int          o_stall;
    int          o_req;
    logic        o_done;
    logic        o_we;
    logic [31:0] o_addr;
    logic [31:0] o_wdata;
    logic [3:0]  o_be;
    logic [31:0] o_load;
    logic        o_to;

    function automatic int m_size(input logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic bit m_aligned(input logic [2:0] f3, input logic [31:0] a);
        return (int'(a % 32'd4) % m_size(f3)) == 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        int lo;
        lo = int'(a % 32'd4);
        if (m_size(f3) == 1) return 4'(1 << lo);
        if (m_size(f3) == 2) return 4'(3 << lo);
        return 4'd15;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        if (m_size(f3) == 1) return (wd & 32'hFF) * 32'h01010101;
        if (m_size(f3) == 2) return (wd & 32'hFFFF) * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] r);
        logic [31:0] b;
        logic [31:0] h;
        int lo;
        lo = int'(a % 32'd4);
        b = (r >> (8 * lo)) & 32'hFF;
        h = (r >> (16 * (lo / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'd128) ? b + 32'hFFFFFF00 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF0000 : h;
            3'd5:    return h;
            default: return r;
        endcase
    endfunction

    // Drives one aligned access; ack_idx is the ACCESS cycle (0-based) carrying ACK, -1 for none.
    task automatic run_access(input bit rd, input bit wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              input int ack_idx, input logic [31:0] rdata);
        o_stall = 0;
        o_req   = 0;
        o_done  = 1'b0;
        @(posedge CLK); #1;
        MEM_READ = rd; MEM_WRITE = wr; FUNCT3 = f3; ADDRESS = a; WRITE_DATA = wd;
        DMEM_RDATA = rdata;
        for (int cyc = 0; cyc < 40; cyc++) begin
            DMEM_ACK = (ack_idx >= 0 && cyc == ack_idx + 1);
            @(negedge CLK);
            if (STALL) o_stall++;
            if (DMEM_REQ) o_req++;
            if (cyc == 1) begin
                o_we = DMEM_WE; o_addr = DMEM_ADDR; o_wdata = DMEM_WDATA; o_be = DMEM_BYTE_EN;
            end
            if (cyc > 0 && !STALL) begin
                o_done = 1'b1;
                o_load = LOAD_DATA;
                o_to   = TIMEOUT_ERR;
                break;
            end
            @(posedge CLK); #1;
        end
        @(posedge CLK); #1;
        MEM_READ = 1'b0; MEM_WRITE = 1'b0; DMEM_ACK = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        checks++;
        if ({STALL, DMEM_REQ, MISALIGNED, TIMEOUT_ERR} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0000", {STALL, DMEM_REQ, MISALIGNED, TIMEOUT_ERR});
        end
        checks++;
        if (LOAD_DATA !== 32'd0 || DMEM_BYTE_EN !== 4'd0 || DMEM_ADDR !== 32'd0) begin
            errors++;
            $display("FAIL reset_regs: got ld=%h be=%b addr=%h want zeros", LOAD_DATA, DMEM_BYTE_EN, DMEM_ADDR);
        end
        exp_ld = 32'd0;
        exp_to = 1'b0;
    endtask

    task automatic test_lw_basic();
        run_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 2, 32'hDEADBEEF);
        checks++;
        if (!o_done) begin errors++; $display("FAIL lw_done: got no completion want DONE"); end
        checks++;
        if (o_addr !== 32'h100 || o_be !== 4'b1111 || o_we !== 1'b0) begin
            errors++;
            $display("FAIL lw_req: got addr=%h be=%b we=%b want 00000100 1111 0", o_addr, o_be, o_we);
        end
        checks++;
        if (o_stall != 4) begin errors++; $display("FAIL lw_stall: got %0d want 4", o_stall); end
        checks++;
        if (o_load !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_load: got %h want deadbeef", o_load); end
        exp_ld = 32'hDEADBEEF;
    endtask

    task automatic test_load_ext();
        run_access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 1, 32'h80112233);
        checks++;
        if (o_load !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_load: got %h want ffffff80", o_load); end
        checks++;
        if (o_stall != 3 || o_be !== 4'b1000) begin
            errors++;
            $display("FAIL lb_req: got stall=%0d be=%b want 3 1000", o_stall, o_be);
        end
        run_access(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 1, 32'h80112233);
        checks++;
        if (o_load !== 32'h00000080) begin errors++; $display("FAIL lbu_load: got %h want 00000080", o_load); end
        run_access(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 1, 32'h80112233);
        checks++;
        if (o_load !== 32'hFFFF8011) begin errors++; $display("FAIL lh_load: got %h want ffff8011", o_load); end
        checks++;
        if (o_be !== 4'b1100) begin errors++; $display("FAIL lh_be: got %b want 1100", o_be); end
        exp_ld = 32'hFFFF8011;
    endtask

    task automatic test_store_byte();
        run_access(1'b0, 1'b1, 3'b000, 32'h201, 32'h000000A5, 0, 32'h12345678);
        checks++;
        if (o_we !== 1'b1 || o_be !== 4'b0010 || o_addr !== 32'h200) begin
            errors++;
            $display("FAIL sb_req: got we=%b be=%b addr=%h want 1 0010 00000200", o_we, o_be, o_addr);
        end
        checks++;
        if (o_wdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL sb_wdata: got %h want a5a5a5a5", o_wdata); end
        checks++;
        if (o_stall != 2 || o_req != 1) begin
            errors++;
            $display("FAIL sb_stall: got stall=%0d req=%0d want 2 1", o_stall, o_req);
        end
        checks++;
        if (o_load !== exp_ld) begin errors++; $display("FAIL sb_load_held: got %h want %h", o_load, exp_ld); end
    endtask

    task automatic test_misaligned();
        @(posedge CLK); #1;
        MEM_READ = 1'b1; FUNCT3 = 3'b010; ADDRESS = 32'h102;
        @(negedge CLK);
        checks++;
        if (STALL !== 1'b0 || DMEM_REQ !== 1'b0) begin
            errors++;
            $display("FAIL mis_nostall: got stall=%b req=%b want 0 0", STALL, DMEM_REQ);
        end
        @(posedge CLK); #1;
        MEM_READ = 1'b0;
        @(negedge CLK);
        checks++;
        if (MISALIGNED !== 1'b1 || LOAD_DATA !== 32'd0 || DMEM_REQ !== 1'b0) begin
            errors++;
            $display("FAIL mis_pulse: got mis=%b ld=%h req=%b want 1 0 0", MISALIGNED, LOAD_DATA, DMEM_REQ);
        end
        @(negedge CLK);
        checks++;
        if (MISALIGNED !== 1'b0) begin errors++; $display("FAIL mis_one_cycle: got %b want 0", MISALIGNED); end
        exp_ld = 32'd0;
    endtask

    task automatic test_timeout();
        run_access(1'b0, 1'b1, 3'b010, 32'h300, 32'hCAFEF00D, -1, 32'h0);
        checks++;
        if (!o_done || o_req != 16 || o_stall != 17) begin
            errors++;
            $display("FAIL tmo_len: got done=%b req=%0d stall=%0d want 1 16 17", o_done, o_req, o_stall);
        end
        checks++;
        if (o_to !== 1'b1 || o_load !== 32'd0) begin
            errors++;
            $display("FAIL tmo_flag: got err=%b ld=%h want 1 0", o_to, o_load);
        end
        exp_to = 1'b1;
        exp_ld = 32'd0;
        run_access(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 1, 32'h12345678);
        checks++;
        if (o_load !== 32'h12345678 || o_stall != 3) begin
            errors++;
            $display("FAIL tmo_recover: got ld=%h stall=%0d want 12345678 3", o_load, o_stall);
        end
        checks++;
        if (o_to !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got %b want 1", o_to); end
        exp_ld = 32'h12345678;
    endtask

    task automatic test_ack_ignored();
        @(posedge CLK); #1;
        DMEM_ACK = 1'b1; DMEM_RDATA = $urandom;
        @(posedge CLK); #1;
        DMEM_ACK = 1'b0;
        @(negedge CLK);
        checks++;
        if (DMEM_REQ !== 1'b0 || STALL !== 1'b0 || LOAD_DATA !== exp_ld) begin
            errors++;
            $display("FAIL ack_idle: got req=%b stall=%b ld=%h want 0 0 %h", DMEM_REQ, STALL, LOAD_DATA, exp_ld);
        end
    endtask

    task automatic test_random();
        logic [2:0]  f3_tab [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rdat;
        int          k;
        int          ack;
        bit          rd;
        bit          wr;
        for (int i = 0; i < 40; i++) begin
            f3   = f3_tab[$urandom_range(0, 7)];
            a    = $urandom;
            wd   = $urandom;
            rdat = $urandom;
            k    = $urandom_range(1, 3);
            rd   = (k % 2) == 1;
            wr   = k >= 2;
            ack  = $urandom_range(0, 5);
            if (!m_aligned(f3, a)) begin
                @(posedge CLK); #1;
                MEM_READ = rd; MEM_WRITE = wr; FUNCT3 = f3; ADDRESS = a;
                @(negedge CLK);
                checks++;
                if (STALL !== 1'b0) begin errors++; $display("FAIL rnd_mis_stall[%0d]: got %b want 0", i, STALL); end
                @(posedge CLK); #1;
                MEM_READ = 1'b0; MEM_WRITE = 1'b0;
                @(negedge CLK);
                checks++;
                if (MISALIGNED !== 1'b1 || DMEM_REQ !== 1'b0) begin
                    errors++;
                    $display("FAIL rnd_mis[%0d]: got mis=%b req=%b want 1 0", i, MISALIGNED, DMEM_REQ);
                end
                exp_ld = 32'd0;
            end else begin
                run_access(rd, wr, f3, a, wd, ack, rdat);
                checks++;
                if (o_addr !== a - (a % 32'd4) || o_be !== m_be(f3, a) || o_we !== wr) begin
                    errors++;
                    $display("FAIL rnd_req[%0d]: got addr=%h be=%b we=%b want %h %b %b",
                             i, o_addr, o_be, o_we, a - (a % 32'd4), m_be(f3, a), wr);
                end
                if (wr) begin
                    checks++;
                    if (o_wdata !== m_wdata(f3, wd)) begin
                        errors++;
                        $display("FAIL rnd_wdata[%0d]: got %h want %h", i, o_wdata, m_wdata(f3, wd));
                    end
                end else begin
                    exp_ld = m_load(f3, a, rdat);
                end
                checks++;
                if (o_stall != ack + 2 || o_load !== exp_ld || o_to !== exp_to) begin
                    errors++;
                    $display("FAIL rnd_done[%0d]: got stall=%0d ld=%h err=%b want %0d %h %b",
                             i, o_stall, o_load, o_to, ack + 2, exp_ld, exp_to);
                end
            end
        end
    endtask

    task automatic test_reset_mid_access();
        @(posedge CLK); #1;
        MEM_READ = 1'b1; MEM_WRITE = 1'b0; FUNCT3 = 3'b010; ADDRESS = 32'h400;
        repeat (2) begin @(posedge CLK); #1; end
        RESET = 1'b1; MEM_READ = 1'b0;
        @(negedge CLK);
        checks++;
        if (DMEM_REQ !== 1'b1) begin errors++; $display("FAIL rst_mid_pre: got req=%b want 1", DMEM_REQ); end
        @(posedge CLK); #1;
        RESET = 1'b0;
        @(negedge CLK);
        checks++;
        if (DMEM_REQ !== 1'b0 || STALL !== 1'b0 || TIMEOUT_ERR !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: got req=%b stall=%b err=%b want 0 0 0", DMEM_REQ, STALL, TIMEOUT_ERR);
        end
        @(posedge CLK); #1;
        DMEM_ACK = 1'b1; DMEM_RDATA = 32'h55AA55AA;
        @(posedge CLK); #1;
        DMEM_ACK = 1'b0;
        @(negedge CLK);
        checks++;
        if (DMEM_REQ !== 1'b0 || STALL !== 1'b0 || LOAD_DATA !== 32'd0) begin
            errors++;
            $display("FAIL rst_late_ack: got req=%b stall=%b ld=%h want 0 0 0", DMEM_REQ, STALL, LOAD_DATA);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RESET = 1'b1; MEM_READ = 1'b0; MEM_WRITE = 1'b0; FUNCT3 = 3'b000;
        ADDRESS = 32'd0; WRITE_DATA = 32'd0; DMEM_ACK = 1'b0; DMEM_RDATA = 32'd0;
        exp_ld = 32'd0; exp_to = 1'b0;
        test_reset();
        test_lw_basic();
        test_load_ext();
        test_store_byte();
        test_misaligned();
        test_timeout();
        test_ack_ignored();
        test_random();
        test_reset_mid_access();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
